prefix_carry_resolver: RTL

PREFIX_CARRY_RESOLVER -- requirements
Module: prefix_carry_resolver

---
 rtl/prefix_carry_resolver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prefix_carry_resolver.sv
// Kogge-Stone carry resolver with valid/ready flow control.
// Optional register after every prefix level; sticky g/p/k encoding check.
module prefix_carry_resolver #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] k,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             enc_err
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NS     = (PIPE != 0) ? LEVELS : 1;

  typedef logic [WIDTH-1:0] vec_t;

  typedef struct packed {
    vec_t g;
    vec_t p;
  } gp_t;

  function automatic gp_t kogge_lvl(
    input gp_t x,
    input int  d
  );
    gp_t  y;
    vec_t low;
    low   = '1;
    low   = ~(low << d);
    y.g   = x.g | (x.p & (x.g << d));
    y.p   = x.p & ((x.p << d) | low);
    return y;
  endfunction

  function automatic gp_t kogge_all(
    input gp_t x
  );
    gp_t y;
    y = x;
    for (int l = 0; l < LEVELS; l++)
      y = kogge_lvl(y, 1 << l);
    return y;
  endfunction

  logic       rdy_q;
  logic       acc;
  logic       ld0;
  logic       ld_o;
  logic       fv;
  logic       fc;
  gp_t        fgp;
  vec_t       fpo;
  logic [WIDTH:0] c;
  vec_t       illegal;

  assign acc      = in_valid & in_ready;
  assign in_ready = rdy_q & ld0;
  assign ld_o     = ~out_valid | out_ready;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [NS:0]   ld;
      logic [NS-1:0] v;
      logic [NS-1:0] cv;
      gp_t           gq [NS];
      vec_t          pq [NS];

      assign ld[NS] = ld_o;

      for (genvar j = 0; j < NS; j++) begin : g_st
        gp_t  ngp;
        vec_t np;
        logic nv;
        logic nc;
        logic vq;
        logic cq;
        gp_t  gpq;
        vec_t pqq;

        if (j == 0) begin : g_in
          assign ngp = kogge_lvl(gp_t'({g, p}), 1);
          assign np  = p;
          assign nc  = cin;
          assign nv  = acc;
        end else begin : g_mid
          assign ngp = kogge_lvl(gq[j-1], 1 << j);
          assign np  = pq[j-1];
          assign nc  = cv[j-1];
          assign nv  = v[j-1];
        end

        // empty stage, or its beat leaves this cycle
        assign ld[j] = ~vq | ld[j+1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vq  <= 1'b0;
            cq  <= 1'b0;
            gpq <= '0;
            pqq <= '0;
          end else if (ld[j]) begin
            vq <= nv;
            if (nv) begin
              cq  <= nc;
              gpq <= ngp;
              pqq <= np;
            end
          end
        end

        assign v[j]  = vq;
        assign cv[j] = cq;
        assign gq[j] = gpq;
        assign pq[j] = pqq;
      end

      assign ld0 = ld[0];
      assign fv  = v[NS-1];
      assign fgp = gq[NS-1];
      assign fpo = pq[NS-1];
      assign fc  = cv[NS-1];
    end else begin : g_comb
      assign ld0 = ld_o;
      assign fv  = acc;
      assign fgp = kogge_all(gp_t'({g, p}));
      assign fpo = p;
      assign fc  = cin;
    end
  endgenerate

  assign c = {fgp.g | (fgp.p & {WIDTH{fc}}), fc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (ld_o) begin
      out_valid <= fv;
      if (fv) begin
        sum  <= fpo ^ c[WIDTH-1:0];
        cout <= c[WIDTH];
      end
    end
  end

  // legal only when exactly one of g/p/k is set
  assign illegal = ~(g ^ p ^ k) | (g & p & k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc && (|illegal))
        enc_err <= 1'b1;
    end
  end

endmodule
